// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master shift engine.
//   spi_state_e : engine states IDLE -> SETUP -> XFER -> HOLD -> GAP -> IDLE
//   DATA_W      : transfer width in bits
//   MODE0..3    : SPI modes as {cpol, cpha} pairs
package spi_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      XFER  = 3'd2,
      HOLD  = 3'd3,
      GAP   = 3'd4
   } spi_state_e;

   typedef struct packed {
      logic cpol;
      logic cpha;
   } spi_mode_t;

   localparam spi_mode_t MODE0 = '{cpol: 1'b0, cpha: 1'b0};
   localparam spi_mode_t MODE1 = '{cpol: 1'b0, cpha: 1'b1};
   localparam spi_mode_t MODE2 = '{cpol: 1'b1, cpha: 1'b0};
   localparam spi_mode_t MODE3 = '{cpol: 1'b1, cpha: 1'b1};

endpackage

// File: rtl/spi_master_shifter_if.sv
// Byte handshake and SPI pin bundle for spi_master_shifter.
//   tx_data/tx_valid/tx_ready : byte in. A byte moves on a clk edge where
//                               tx_valid and tx_ready are both high; tx_valid
//                               seen while tx_ready is low has no effect and
//                               tx_data need only be stable at that edge.
//   rx_data/rx_valid          : byte out; rx_valid is a one-cycle strobe,
//                               there is no back-pressure on it.
//   busy                      : transfer in progress
//   sclk/mosi/miso/cs_n       : SPI pins
// Modports: master = the SPI engine, slave = the user of the engine.
interface spi_master_shifter_if
   import spi_pkg::*;
   ();

   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              busy;
   logic              sclk;
   logic              mosi;
   logic              miso;
   logic              cs_n;

   modport master (
      input  tx_data, tx_valid, miso,
      output tx_ready, rx_data, rx_valid, busy, sclk, mosi, cs_n
   );

   modport slave (
      output tx_data, tx_valid, miso,
      input  tx_ready, rx_data, rx_valid, busy, sclk, mosi, cs_n
   );

endinterface

// File: rtl/spi_clk_gen.sv
// sclk timing generator: a CLK_DIV half-period down-counter.
//   clk, reset : system clock, asynchronous active-low reset
//   en_i       : high while a transfer is in SETUP/XFER/HOLD/GAP
//   edge_o     : one-cycle strobe every CLK_DIV cycles while enabled
//   leading_o  : strobe is a leading edge (first, third, ... strobe)
module spi_clk_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic en_i,
   output logic edge_o,
   output logic leading_o
);

   localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

   logic [7:0] cnt_q, cnt_d;
   logic       phase_q, phase_d;

   // Counter rests at CLK_DIV-1 while disabled so the first strobe lands
   // exactly CLK_DIV cycles after the engine leaves IDLE.
   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (!en_i) begin
         cnt_d   = RELOAD;
         phase_d = 1'b0;
      end else if (cnt_q == 8'd0) begin
         cnt_d   = RELOAD;
         phase_d = ~phase_q;
      end else begin
         cnt_d = cnt_q - 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q   <= 8'd0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign edge_o    = en_i && (cnt_q == 8'd0);
   assign leading_o = ~phase_q;

endmodule

// File: rtl/spi_master_shifter.sv
// SPI master shift engine feeding the 8-bit capture register stage.
//   clk, reset  : system clock, asynchronous active-low reset
//   bus         : byte handshake + SPI pins (master modport)
//   dbg_state_o : current engine state
// One byte per transfer, MSB first. rx_valid pulses for one cycle when
// rx_data is loaded, at the HOLD -> GAP transition.
module spi_master_shifter
   import spi_pkg::*;
#(
   parameter int   CLK_DIV = 2,
   parameter logic CPOL    = 1'b0,
   parameter logic CPHA    = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   spi_master_shifter_if.master bus,
   output spi_state_e           dbg_state_o
);

   spi_state_e        state_q;
   logic              sclk_q, mosi_q, cs_n_q, tx_ready_q, busy_q, rx_valid_q;
   logic [DATA_W-1:0] tx_sr_q, rx_sr_q, rx_data_q;
   logic [3:0]        edge_cnt_q;

   logic sclk_edge, leading, sample, drive;

   spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
      .clk       (clk),
      .reset     (reset),
      .en_i      (state_q != IDLE),
      .edge_o    (sclk_edge),
      .leading_o (leading)
   );

   // CPHA=0: sample on leading edges, shift out on trailing edges (the
   // first bit goes out at accept, the last trailing edge shifts nothing).
   // CPHA=1: shift out on leading edges, sample on trailing edges.
   assign sample = CPHA ? ~leading : leading;
   assign drive  = CPHA ? leading : (~leading && (edge_cnt_q != 4'd15));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         sclk_q     <= CPOL;
         mosi_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         tx_ready_q <= 1'b1;
         busy_q     <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         tx_sr_q    <= '0;
         rx_sr_q    <= '0;
         edge_cnt_q <= 4'd0;
      end else begin
         rx_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.tx_valid && tx_ready_q) begin
                  tx_sr_q    <= bus.tx_data;
                  rx_sr_q    <= '0;
                  edge_cnt_q <= 4'd0;
                  cs_n_q     <= 1'b0;
                  busy_q     <= 1'b1;
                  tx_ready_q <= 1'b0;
                  mosi_q     <= CPHA ? 1'b0 : bus.tx_data[DATA_W-1];
                  state_q    <= SETUP;
               end
            end
            // The SETUP strobe is sclk edge 0, so both states share the
            // edge handling; edge_cnt_q indexes the edge being taken.
            SETUP, XFER: begin
               if (sclk_edge) begin
                  sclk_q <= ~sclk_q;
                  if (sample) rx_sr_q <= {rx_sr_q[DATA_W-2:0], bus.miso};
                  if (drive) begin
                     mosi_q  <= CPHA ? tx_sr_q[DATA_W-1] : tx_sr_q[DATA_W-2];
                     tx_sr_q <= {tx_sr_q[DATA_W-2:0], 1'b0};
                  end
                  if (edge_cnt_q == 4'd15) begin
                     state_q <= HOLD;
                  end else begin
                     edge_cnt_q <= edge_cnt_q + 4'd1;
                     state_q    <= XFER;
                  end
               end
            end
            HOLD: begin
               if (sclk_edge) begin
                  cs_n_q     <= 1'b1;
                  rx_data_q  <= rx_sr_q;
                  rx_valid_q <= 1'b1;
                  mosi_q     <= 1'b0;
                  state_q    <= GAP;
               end
            end
            GAP: begin
               if (sclk_edge) begin
                  tx_ready_q <= 1'b1;
                  busy_q     <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.sclk     = sclk_q;
   assign bus.mosi     = mosi_q;
   assign bus.cs_n     = cs_n_q;
   assign bus.tx_ready = tx_ready_q;
   assign bus.busy     = busy_q;
   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_spi_master_shifter.sv
// Bench for spi_master_shifter: three instances (CLK_DIV=2 mode 0,
// CLK_DIV=3 mode 3, CLK_DIV=1 mode 0), a protocol-level SPI slave and
// mosi monitor, a vector table, hand-written corner sequences and a
// randomized run checked against timing/data rules.
module tb_spi_master_shifter;
   import spi_pkg::*;

   localparam logic [2:0] CPOL_V = 3'b010;
   localparam logic [2:0] CPHA_V = 3'b010;

   function automatic int div_of(input int g);
      case (g)
         0:       return 2;
         1:       return 3;
         default: return 1;
      endcase
   endfunction

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT instances ----------------
   logic [2:0]       tx_valid = '0;
   logic [2:0][7:0]  tx_data  = '0;
   logic [2:0]       miso;
   logic [2:0]       tx_ready_w, rx_valid_w, busy_w, sclk_w, mosi_w, cs_n_w;
   logic [2:0][7:0]  rx_data_w;
   logic [2:0][2:0]  dbg_w;

   logic [2:0] loop_en   = '0;
   logic [2:0] slave_bit = '0;
   assign miso = (loop_en & mosi_w) | (~loop_en & slave_bit);

   for (genvar g = 0; g < 3; g++) begin : g_dut
      spi_master_shifter_if u_if ();
      assign u_if.tx_data  = tx_data[g];
      assign u_if.tx_valid = tx_valid[g];
      assign u_if.miso     = miso[g];
      assign tx_ready_w[g] = u_if.tx_ready;
      assign rx_valid_w[g] = u_if.rx_valid;
      assign busy_w[g]     = u_if.busy;
      assign sclk_w[g]     = u_if.sclk;
      assign mosi_w[g]     = u_if.mosi;
      assign cs_n_w[g]     = u_if.cs_n;
      assign rx_data_w[g]  = u_if.rx_data;
      spi_master_shifter #(
         .CLK_DIV (div_of(g)),
         .CPOL    (CPOL_V[g]),
         .CPHA    (CPHA_V[g])
      ) u_dut (
         .clk         (clk),
         .reset       (reset),
         .bus         (u_if.master),
         .dbg_state_o (dbg_w[g])
      );
   end

   // ---------------- SPI slave model + mosi monitor ----------------
   // Slave shifts slv_byte out MSB first: for CPHA=0 the first bit appears
   // when cs_n falls and later bits after each trailing edge; for CPHA=1
   // every bit appears after a leading edge. The monitor records mosi at
   // each sampling edge, and counts sclk toggles and rising sampling edges.
   logic [7:0] slv_byte [3];
   int         slv_idx  [3];
   logic [7:0] mon_mosi [3];
   int         mon_cnt  [3];
   int         mon_rise [3];
   int         mon_tog  [3];
   logic [2:0] cs_prev   = '1;
   logic [2:0] sclk_prev = CPOL_V;

   always @(negedge clk) begin
      for (int g = 0; g < 3; g++) begin
         if (!cs_n_w[g] && cs_prev[g]) begin
            mon_mosi[g] = '0;
            mon_cnt[g]  = 0;
            mon_rise[g] = 0;
            mon_tog[g]  = 0;
            slv_idx[g]  = 7;
            if (!CPHA_V[g]) begin
               slave_bit[g] = slv_byte[g][7];
               slv_idx[g]   = 6;
            end
         end
         if (!cs_n_w[g] && (sclk_w[g] != sclk_prev[g])) begin
            mon_tog[g]++;
            // leading edge = sclk leaving its idle level
            if ((sclk_w[g] != CPOL_V[g]) == !CPHA_V[g]) begin
               mon_mosi[g] = {mon_mosi[g][6:0], mosi_w[g]};
               mon_cnt[g]++;
               if (sclk_w[g]) mon_rise[g]++;
            end else if (slv_idx[g] >= 0) begin
               slave_bit[g] = slv_byte[g][slv_idx[g]];
               slv_idx[g]--;
            end
         end
         cs_prev[g]   = cs_n_w[g];
         sclk_prev[g] = sclk_w[g];
      end
   end

   // ---------------- scoreboard / checking ----------------
   int errors = 0;
   int checks = 0;
   logic [7:0] exp_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      int         t_rxv;
      int         t_rdy;
      int         rxv_cnt;
      int         cs_first;
      int         cs_last;
      int         setup_bad;
      logic [7:0] rx;
      logic       busy1;
      logic       mosi1;
      logic [2:0] st1;
   } meas_t;

   // Runs one transfer on instance g starting at a negedge. Cycle n is the
   // n-th negedge after the accepting posedge (T0+n).
   task automatic xfer(input int g, input logic [7:0] tx, input logic [7:0] sb,
                       input logic loop, input logic toggle, output meas_t m);
      int d;
      d = div_of(g);
      m = '{default: 0};
      slv_byte[g] = sb;
      loop_en[g]  = loop;
      tx_data[g]  = tx;
      tx_valid[g] = 1'b1;
      for (int i = 0; i < 100 && !tx_ready_w[g]; i++) @(negedge clk);
      @(negedge clk);
      tx_valid[g] = 1'b0;
      for (int n = 1; n <= 18 * d + 4; n++) begin
         if (n > 1) @(negedge clk);
         if (toggle) begin
            tx_valid[g] = (n < 16) ? n[0] : 1'b0;
            tx_data[g]  = 8'($urandom);
         end
         if (n == 1) begin
            m.busy1 = busy_w[g];
            m.mosi1 = mosi_w[g];
            m.st1   = dbg_w[g];
         end
         if (!cs_n_w[g]) begin
            if (m.cs_first == 0) m.cs_first = n;
            m.cs_last = n;
         end
         if (rx_valid_w[g]) begin
            m.rxv_cnt++;
            m.t_rxv = n;
            m.rx    = rx_data_w[g];
         end
         if (n <= d && sclk_w[g] !== CPOL_V[g]) m.setup_bad++;
         if (tx_ready_w[g]) begin
            m.t_rdy = n;
            break;
         end
      end
      tx_valid[g] = 1'b0;
   endtask

   typedef struct {
      int         g;
      logic [7:0] tx;
      logic [7:0] sb;
      logic       loop;
      logic       toggle;
      logic [7:0] exp_rx;
      int         exp_rxv;
      int         exp_rdy;
   } vec_t;

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t  vecs [4];
      meas_t m;
      int    g, d, n_rxv, t_rxv0, t_rxv1, cs_hi;
      logic [7:0] rx0, rx1, tx, sb, e;
      logic  loop;

      vecs[0] = '{g: 0, tx: 8'hA5, sb: 8'h00, loop: 1'b1, toggle: 1'b0, exp_rx: 8'hA5, exp_rxv: 35, exp_rdy: 37};
      vecs[1] = '{g: 0, tx: 8'hC3, sb: 8'h3C, loop: 1'b0, toggle: 1'b0, exp_rx: 8'h3C, exp_rxv: 35, exp_rdy: 37};
      vecs[2] = '{g: 1, tx: 8'h7E, sb: 8'h81, loop: 1'b0, toggle: 1'b0, exp_rx: 8'h81, exp_rxv: 52, exp_rdy: 55};
      vecs[3] = '{g: 2, tx: 8'h96, sb: 8'h69, loop: 1'b0, toggle: 1'b1, exp_rx: 8'h69, exp_rxv: 18, exp_rdy: 19};
      for (int i = 0; i < 3; i++) slv_byte[i] = '0;

      // reset values
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("rst_cs_n",     32'(cs_n_w[i]),     32'd1);
         chk("rst_sclk",     32'(sclk_w[i]),     32'(CPOL_V[i]));
         chk("rst_mosi",     32'(mosi_w[i]),     32'd0);
         chk("rst_tx_ready", 32'(tx_ready_w[i]), 32'd1);
         chk("rst_busy",     32'(busy_w[i]),     32'd0);
         chk("rst_rx_valid", 32'(rx_valid_w[i]), 32'd0);
         chk("rst_rx_data",  32'(rx_data_w[i]),  32'd0);
         chk("rst_state",    32'(dbg_w[i]),      32'(IDLE));
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // table-driven transfers
      foreach (vecs[i]) begin
         xfer(vecs[i].g, vecs[i].tx, vecs[i].sb, vecs[i].loop, vecs[i].toggle, m);
         chk("vec_rx_data",  32'(m.rx),       32'(vecs[i].exp_rx));
         chk("vec_t_rxv",    32'(m.t_rxv),    32'(vecs[i].exp_rxv));
         chk("vec_t_ready",  32'(m.t_rdy),    32'(vecs[i].exp_rdy));
         chk("vec_rxv_cnt",  32'(m.rxv_cnt),  32'd1);
         chk("vec_cs_first", 32'(m.cs_first), 32'd1);
         chk("vec_cs_last",  32'(m.cs_last),  32'(vecs[i].exp_rxv - 1));
         chk("vec_setup",    32'(m.setup_bad), 32'd0);
         chk("vec_busy1",    32'(m.busy1),    32'd1);
         chk("vec_state1",   32'(m.st1),      32'(SETUP));
         chk("vec_mosi1",    32'(m.mosi1),    CPHA_V[vecs[i].g] ? 32'd0 : 32'(vecs[i].tx[7]));
         chk("vec_mosi_seq", 32'(mon_mosi[vecs[i].g]), 32'(vecs[i].tx));
         chk("vec_samples",  32'(mon_cnt[vecs[i].g]),  32'd8);
         chk("vec_rising",   32'(mon_rise[vecs[i].g]), 32'd8);
         chk("vec_toggles",  32'(mon_tog[vecs[i].g]),  32'd16);
      end

      // back-to-back with tx_valid held high, instance 0 (CLK_DIV=2)
      loop_en[0]  = 1'b1;
      tx_data[0]  = 8'h11;
      tx_valid[0] = 1'b1;
      n_rxv = 0; t_rxv0 = 0; t_rxv1 = 0; rx0 = '0; rx1 = '0; cs_hi = 0;
      for (int i = 0; i < 100 && !tx_ready_w[0]; i++) @(negedge clk);
      for (int n = 1; n <= 80; n++) begin
         @(negedge clk);
         if (n == 2)  tx_data[0]  = 8'h22;
         if (n == 38) tx_valid[0] = 1'b0;
         if (n >= 2 && n <= 70 && cs_n_w[0]) cs_hi++;
         if (rx_valid_w[0]) begin
            if (n_rxv == 0) begin t_rxv0 = n; rx0 = rx_data_w[0]; end
            else            begin t_rxv1 = n; rx1 = rx_data_w[0]; end
            n_rxv++;
         end
      end
      chk("b2b_rxv_count", 32'(n_rxv),  32'd2);
      chk("b2b_t_rxv0",    32'(t_rxv0), 32'd35);
      chk("b2b_rx0",       32'(rx0),    32'h11);
      chk("b2b_t_rxv1",    32'(t_rxv1), 32'd72);
      chk("b2b_rx1",       32'(rx1),    32'h22);
      chk("b2b_cs_high",   32'(cs_hi),  32'(div_of(0) + 1));

      // reset after edge 5 of a 0xFF transfer, instance 0
      loop_en[0]  = 1'b0;
      slv_byte[0] = 8'hFF;
      tx_data[0]  = 8'hFF;
      tx_valid[0] = 1'b1;
      for (int i = 0; i < 100 && !tx_ready_w[0]; i++) @(negedge clk);
      @(negedge clk);
      tx_valid[0] = 1'b0;
      repeat (13) @(negedge clk);
      chk("rst_mid_edges", 32'(mon_tog[0]), 32'd6);
      reset = 1'b0;
      #1;
      chk("rst_mid_cs_n",     32'(cs_n_w[0]),     32'd1);
      chk("rst_mid_sclk",     32'(sclk_w[0]),     32'(CPOL_V[0]));
      chk("rst_mid_rx_data",  32'(rx_data_w[0]),  32'd0);
      chk("rst_mid_rx_valid", 32'(rx_valid_w[0]), 32'd0);
      chk("rst_mid_busy",     32'(busy_w[0]),     32'd0);
      chk("rst_mid_tx_ready", 32'(tx_ready_w[0]), 32'd1);
      n_rxv = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (rx_valid_w[0]) n_rxv++;
      end
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (rx_valid_w[0]) n_rxv++;
      end
      chk("rst_mid_no_rxv", 32'(n_rxv), 32'd0);
      xfer(0, 8'h5A, 8'h00, 1'b1, 1'b0, m);
      chk("rst_after_rx",    32'(m.rx),    32'h5A);
      chk("rst_after_t_rxv", 32'(m.t_rxv), 32'd35);
      chk("rst_after_t_rdy", 32'(m.t_rdy), 32'd37);

      // randomized transfers against the rule-based model
      for (int i = 0; i < 24; i++) begin
         g    = $urandom_range(0, 2);
         d    = div_of(g);
         tx   = 8'($urandom_range(0, 255));
         sb   = 8'($urandom_range(0, 255));
         loop = 1'($urandom_range(0, 1));
         exp_q.push_back(loop ? tx : sb);
         xfer(g, tx, sb, loop, 1'b0, m);
         e = exp_q.pop_front();
         chk("rand_rx_data", 32'(m.rx),      32'(e));
         chk("rand_t_rxv",   32'(m.t_rxv),   32'(1 + 17 * d));
         chk("rand_t_ready", 32'(m.t_rdy),   32'(1 + 18 * d));
         chk("rand_rxv_cnt", 32'(m.rxv_cnt), 32'd1);
         chk("rand_mosi",    32'(mon_mosi[g]), 32'(tx));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
